// File: rtl/multiplier32_pkg.sv
// Shared ALU port bundles and multiplier FSM state encoding.
// Purely declarative; no logic, no latency, no flow control.
package PkgAlu;

    localparam int MSB_POS__MUL32_INOUT = 31;

    typedef struct packed {
        logic                            enable;
        logic [MSB_POS__MUL32_INOUT:0]   x;
        logic [MSB_POS__MUL32_INOUT:0]   y;
    } PortIn_Multiplier32;

    typedef struct packed {
        logic                            can_accept_cmd;
        logic                            data_ready;
        logic [MSB_POS__MUL32_INOUT:0]   prod;
    } PortOut_Multiplier32;

    typedef enum logic {StIdle, StBusy} Mul32State;

endpackage

// File: rtl/multiplier32_chunk_pp.sv
// 32 x BITS_PER_CYCLE partial product, truncated to 32 bits.
// Combinational, zero latency; no flow control.
module mul32_chunk_pp #(
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic [31:0]               x,
    input  logic [BITS_PER_CYCLE-1:0] y_chunk,
    output logic [31:0]               pp
);

    // Only the low 32 bits are ever consumed, so a 32-bit multiply suffices.
    assign pp = x * 32'(y_chunk);

endmodule

// File: rtl/multiplier32.sv
// Iterative 32x32 multiplier returning the low 32 bits, BITS_PER_CYCLE bits of y per clock.
// Latency: accept at edge k -> data_ready after edge k+NUM_ITER.
// Backpressure: can_accept_cmd low while busy; enable is ignored then.
module multiplier32
    import PkgAlu::*;
#(
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  PortIn_Multiplier32  in,
    output PortOut_Multiplier32 out
);

    localparam int NUM_ITER = 32 / BITS_PER_CYCLE;
    localparam int CW       = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

    generate
        if (!(BITS_PER_CYCLE inside {1, 2, 4, 8, 16, 32})) begin : g_bad_bpc
            $error("multiplier32: BITS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32");
        end
    endgenerate

    Mul32State      state;
    logic [CW-1:0]  cnt;
    logic [31:0]    x_r;
    logic [31:0]    y_r;
    logic [31:0]    acc;
    logic           can_accept_r;
    logic           data_ready_r;
    logic [31:0]    prod_r;

    logic [31:0]    pp;
    logic [31:0]    shift_amt;
    logic [31:0]    acc_next;
    logic           last_iter;

    mul32_chunk_pp #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_chunk_pp (
        .x       (x_r),
        .y_chunk (y_r[BITS_PER_CYCLE-1:0]),
        .pp      (pp)
    );

    assign shift_amt = 32'(cnt) * 32'(BITS_PER_CYCLE);
    assign acc_next  = acc + (pp << shift_amt);
    assign last_iter = (cnt == CW'(NUM_ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            cnt          <= '0;
            x_r          <= '0;
            y_r          <= '0;
            acc          <= '0;
            can_accept_r <= 1'b1;
            data_ready_r <= 1'b0;
            prod_r       <= '0;
        end else begin
            data_ready_r <= 1'b0;
            case (state)
                StIdle: begin
                    if (in.enable) begin
                        x_r          <= in.x;
                        y_r          <= in.y;
                        acc          <= '0;
                        cnt          <= '0;
                        can_accept_r <= 1'b0;
                        state        <= StBusy;
                    end
                end
                StBusy: begin
                    acc <= acc_next;
                    y_r <= y_r >> BITS_PER_CYCLE;
                    cnt <= cnt + CW'(1);
                    // prod is only written here, so it holds across later accepts.
                    if (last_iter) begin
                        prod_r       <= acc_next;
                        data_ready_r <= 1'b1;
                        can_accept_r <= 1'b1;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign out.can_accept_cmd = can_accept_r;
    assign out.data_ready     = data_ready_r;
    assign out.prod           = prod_r;

endmodule

// File: tb/tb_multiplier32.sv
// Scoreboard bench for multiplier32: directed cases on the default build plus a
// random sweep across four BITS_PER_CYCLE builds driven in lockstep.
module tb_multiplier32;
    import PkgAlu::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    PortIn_Multiplier32  din;
    PortOut_Multiplier32 dout;

    multiplier32 #(.BITS_PER_CYCLE(8)) dut (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (dout)
    );

    PortIn_Multiplier32  sw_in  [4];
    PortOut_Multiplier32 sw_out [4];

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int B = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 16 : 32;
        multiplier32 #(.BITS_PER_CYCLE(B)) u_dut (
            .clk (clk),
            .rst (rst),
            .in  (sw_in[g]),
            .out (sw_out[g])
        );
    end

    function automatic int sw_lat(input int g);
        int b;
        b = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 16 : 32;
        return 32 / b + 1;
    endfunction

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];
    logic [31:0] sw_q  [4][$];

    // Advance until data_ready; lat counts cycles from the drive cycle, -1 on timeout.
    task automatic wait_dr(input int start, input bit keep, output int lat,
                           output bit busy_bad, output logic [31:0] p);
        lat = start;
        busy_bad = 1'b0;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            lat++;
            if (!keep) din.enable = 1'b0;
            if (dout.data_ready) begin
                p = dout.prod;
                return;
            end
            if (dout.can_accept_cmd) busy_bad = 1'b1;
        end
        lat = -1;
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y);
        din.enable = 1'b1;
        din.x = x;
        din.y = y;
        exp_q.push_back(x * y);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dout.can_accept_cmd !== 1'b1) begin
            errors++; $display("FAIL reset_can_accept got=%b exp=1", dout.can_accept_cmd);
        end
        checks++;
        if (dout.data_ready !== 1'b0) begin
            errors++; $display("FAIL reset_data_ready got=%b exp=0", dout.data_ready);
        end
        checks++;
        if (dout.prod !== 32'h0) begin
            errors++; $display("FAIL reset_prod got=%h exp=00000000", dout.prod);
        end
    endtask

    task automatic test_basic();
        int lat; bit bb; logic [31:0] p, e;
        drive(32'd3, 32'd5);
        wait_dr(0, 1'b0, lat, bb, p);
        e = exp_q.pop_front();
        checks++;
        if (lat !== N + 1) begin
            errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, N + 1);
        end
        checks++;
        if (p !== e) begin
            errors++; $display("FAIL basic_prod got=%h exp=%h", p, e);
        end
        checks++;
        if (bb) begin
            errors++; $display("FAIL basic_busy_can_accept got=1 exp=0");
        end
        @(negedge clk);
        checks++;
        if (dout.data_ready !== 1'b0) begin
            errors++; $display("FAIL basic_pulse_width got=%b exp=0", dout.data_ready);
        end
        checks++;
        if (dout.prod !== 32'h0000000F) begin
            errors++; $display("FAIL basic_prod_hold got=%h exp=0000000f", dout.prod);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] xs [3];
        logic [31:0] ys [3];
        logic [31:0] es [3];
        int lat; bit bb; logic [31:0] p, e;
        xs = '{32'hFFFFFFFF, 32'h00010000, 32'h00012345};
        ys = '{32'hFFFFFFFF, 32'h00010000, 32'h00000100};
        es = '{32'h00000001, 32'h00000000, 32'h01234500};
        for (int i = 0; i < 3; i++) begin
            drive(xs[i], ys[i]);
            wait_dr(0, 1'b0, lat, bb, p);
            e = exp_q.pop_front();
            checks++;
            if (p !== es[i] || p !== e) begin
                errors++; $display("FAIL wrap_prod_%0d got=%h exp=%h", i, p, es[i]);
            end
            checks++;
            if (lat !== N + 1) begin
                errors++; $display("FAIL wrap_latency_%0d got=%0d exp=%0d", i, lat, N + 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit bb; logic [31:0] p, e;
        drive(32'd2, 32'hFFFFFFFF);
        @(negedge clk);
        // New operands held with enable high for the whole busy period.
        din.x = 32'd7;
        din.y = 32'd9;
        wait_dr(1, 1'b1, lat, bb, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== 32'hFFFFFFFE || p !== e) begin
            errors++; $display("FAIL b2b_first_prod got=%h exp=fffffffe", p);
        end
        checks++;
        if (lat !== N + 1) begin
            errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, N + 1);
        end
        checks++;
        if (bb) begin
            errors++; $display("FAIL b2b_busy_can_accept got=1 exp=0");
        end
        exp_q.push_back(32'd7 * 32'd9);
        wait_dr(0, 1'b0, lat, bb, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== 32'h0000003F || p !== e) begin
            errors++; $display("FAIL b2b_second_prod got=%h exp=0000003f", p);
        end
        checks++;
        if (lat !== N + 1) begin
            errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, N + 1);
        end
        begin
            bit extra;
            extra = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (dout.data_ready) extra = 1'b1;
            end
            checks++;
            if (extra) begin
                errors++; $display("FAIL b2b_no_extra_result got=1 exp=0");
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit bb, extra; logic [31:0] p, e;
        din.enable = 1'b1;
        din.x = 32'h1234;
        din.y = 32'h5678;
        @(negedge clk);
        din.enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        din.enable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        din.enable = 1'b0;
        checks++;
        if (dout.can_accept_cmd !== 1'b1) begin
            errors++; $display("FAIL midrst_can_accept got=%b exp=1", dout.can_accept_cmd);
        end
        checks++;
        if (dout.prod !== 32'h0) begin
            errors++; $display("FAIL midrst_prod got=%h exp=00000000", dout.prod);
        end
        extra = dout.data_ready;
        repeat (10) begin
            @(negedge clk);
            if (dout.data_ready) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++; $display("FAIL midrst_no_data_ready got=1 exp=0");
        end
        drive(32'd6, 32'd7);
        wait_dr(0, 1'b0, lat, bb, p);
        e = exp_q.pop_front();
        checks++;
        if (p !== 32'h0000002A || p !== e) begin
            errors++; $display("FAIL midrst_next_prod got=%h exp=0000002a", p);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [31:0] corner [4];
        logic [31:0] x, y, e;
        bit done [4];
        int lat;
        corner = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1};
        for (int t = 0; t < 1000; t++) begin
            x = (t < 16) ? corner[t % 4] : $urandom;
            y = (t < 16) ? corner[t / 4] : $urandom;
            for (int g = 0; g < 4; g++) begin
                sw_in[g].enable = 1'b1;
                sw_in[g].x = x;
                sw_in[g].y = y;
                sw_q[g].push_back(x * y);
                done[g] = 1'b0;
            end
            lat = 0;
            while (lat < 40 && !(done[0] && done[1] && done[2] && done[3])) begin
                @(negedge clk);
                lat++;
                for (int g = 0; g < 4; g++) begin
                    sw_in[g].enable = 1'b0;
                    if (!done[g] && sw_out[g].data_ready) begin
                        done[g] = 1'b1;
                        e = sw_q[g].pop_front();
                        checks++;
                        if (sw_out[g].prod !== e) begin
                            errors++;
                            $display("FAIL sweep_prod g=%0d x=%h y=%h got=%h exp=%h",
                                     g, x, y, sw_out[g].prod, e);
                        end
                        checks++;
                        if (lat !== sw_lat(g)) begin
                            errors++;
                            $display("FAIL sweep_latency g=%0d got=%0d exp=%0d", g, lat, sw_lat(g));
                        end
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                if (!done[g]) begin
                    checks++;
                    errors++;
                    $display("FAIL sweep_timeout g=%0d got=none exp=data_ready", g);
                    void'(sw_q[g].pop_front());
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int g = 0; g < 4; g++) sw_in[g] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
